regfile_access_ctrl: RTL and testbench
======================================

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 Parameter: RR_ENABLE, default 1, meaning 1 = round-robin wb0/wb1 arbitration, 0 = fixed priority wb1 > wb0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wb0_valid / wb0_ready  input / output  1 / 1  ALU writeback handshake.
REQ-005 wb0_rd / wb0_data  input  5 / 32  ALU writeback destination and data.
REQ-006 wb1_valid / wb1_ready  input / output  1 / 1  load-unit writeback handshake.
REQ-007 wb1_rd / wb1_data  input  5 / 32  load writeback destination and data.
REQ-008 dbg_req / dbg_we  input  1 / 1  debug access request (four-phase) and write enable.
REQ-009 dbg_addr / dbg_wdata  input  5 / 32  debug register index and write data.
REQ-010 dbg_ack / dbg_rdata  output  1 / 32  debug completion and registered read data.
REQ-011 core_rs1  input  5  core's rs1 index, passed through when no debug access.
REQ-012 rf_rs1  output  5  register-file rs1 index.
REQ-013 rf_rd1  input  32  register-file rs1 read data (combinational, x0 reads 0).
REQ-014 rf_writeReg / rf_writeData / rf_regWrite  output  5 / 32 / 1  register-file write port.
REQ-015 core_stall  output  1  core must hold issue while asserted.

Function
REQ-016 FSM states: IDLE, DRAIN, ACCESS, ACK.
REQ-017 IDLE: dbg_req=1 -> DRAIN next cycle; otherwise stay.
REQ-018 DRAIN: wb0_valid=0 and wb1_valid=0 in a cycle -> ACCESS next cycle; else stay; writebacks still arbitrated.
REQ-019 ACCESS: exactly one cycle; rf_rs1=dbg_addr; dbg_rdata <= rf_rd1 at end of cycle; if dbg_we and dbg_addr!=0, rf_regWrite=1, rf_writeReg=dbg_addr, rf_writeData=dbg_wdata; -> ACK.
REQ-020 Debug write+read in same ACCESS returns pre-write value in dbg_rdata.
REQ-021 ACK: dbg_ack=1; stay while dbg_req=1; dbg_req=0 -> IDLE next cycle (dbg_ack low in IDLE).
REQ-022 dbg_req dropped during DRAIN -> IDLE next cycle, no access, no ack.
REQ-023 core_stall=1 in DRAIN, ACCESS, ACK; 0 in IDLE.
REQ-024 rf_rs1=core_rs1 in IDLE, DRAIN, ACK.
REQ-025 wb0_ready/wb1_ready=0 in ACCESS and ACK; at most one ready high per cycle.
REQ-026 IDLE/DRAIN, one valid: that requester's ready=1 same cycle (combinational).
REQ-027 Both valid, RR_ENABLE=1: grant requester not granted most recently; last-grant pointer updates only on a completed transfer (valid&ready).
REQ-028 Both valid, RR_ENABLE=0: wb1 always wins.
REQ-029 Granted writeback drives rf_writeReg/rf_writeData from that requester; rf_regWrite=1 unless rd=0.
REQ-030 Writeback with rd=0: handshake completes (ready=1), rf_regWrite=0.
REQ-031 No grant/no debug write: rf_regWrite=0, rf_writeReg=0, rf_writeData=0.
REQ-032 Grant logic uses valid only; ready not contingent on any other output.

Reset
REQ-033 reset=1 at rising edge: state=IDLE, dbg_rdata=0, last-grant pointer=wb1 (wb0 wins first contention).
REQ-034 During reset: dbg_ack=0, core_stall=0, both readies=0, rf_regWrite=0.
REQ-035 Reset mid-debug (any state) aborts access: no ack, no write after reset cycle; new dbg_req restarts from IDLE.

Verification
REQ-036 wb0_valid=1 rd=5 data=0xDEADBEEF alone -> same cycle wb0_ready=1, rf_regWrite=1, rf_writeReg=5, rf_writeData=0xDEADBEEF.
REQ-037 Both valid, held 4 cycles after reset, RR_ENABLE=1 -> grants wb0,wb1,wb0,wb1; RR_ENABLE=0 -> wb1 all 4.
REQ-038 dbg_req=1, dbg_we=0, dbg_addr=7 (x7=0x12345678), no writebacks -> DRAIN 1 cycle, ACCESS 1 cycle, dbg_ack=1 third cycle onward, dbg_rdata=0x12345678, core_stall high throughout.
REQ-039 dbg_req while wb1_valid held 3 cycles -> stays DRAIN, wb1 writes complete, ACCESS only after wb1_valid=0.
REQ-040 Debug write dbg_addr=0 dbg_wdata=0xFFFFFFFF -> rf_regWrite=0, dbg_ack=1, dbg_rdata=0; wb0 rd=0 -> ready=1, rf_regWrite=0.
REQ-041 reset=1 asserted in ACK -> next cycle IDLE, dbg_ack=0, core_stall=0, dbg_rdata=0.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller.
// Arbitrates two writeback sources (ALU on wb0, load unit on wb1) onto the single
// register-file write port. Also sequences four-phase debug accesses: drain the
// pending writebacks, take over the rs1 read port and the write port for one cycle,
// then hold the acknowledge until the debugger releases its request.
module regfile_access_ctrl #(
  parameter int RR_ENABLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  // ALU writeback
  input  logic        wb0_valid,
  output logic        wb0_ready,
  input  logic [4:0]  wb0_rd,
  input  logic [31:0] wb0_data,
  // Load-unit writeback
  input  logic        wb1_valid,
  output logic        wb1_ready,
  input  logic [4:0]  wb1_rd,
  input  logic [31:0] wb1_data,
  // Debug access port
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  // Register-file read port 1
  input  logic [4:0]  core_rs1,
  output logic [4:0]  rf_rs1,
  input  logic [31:0] rf_rd1,
  // Register-file write port
  output logic [4:0]  rf_writeReg,
  output logic [31:0] rf_writeData,
  output logic        rf_regWrite,
  // Core issue hold
  output logic        core_stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_e;

  localparam logic RR_MODE = (RR_ENABLE != 0);

  state_e      state_q;
  logic        dbg_ack_q;
  logic        core_stall_q;
  logic [31:0] dbg_rdata_q;
  // 1 = wb1 completed the most recent transfer, so wb0 wins the next contention.
  logic        last_wb1_q;
  logic        last_wb1_d;

  logic        arb_en;
  logic        wb0_first;
  logic        grant0;
  logic        grant1;
  logic        dbg_wr;

  // Debug sequencing FSM; acknowledge and stall are registered with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dbg_ack_q    <= 1'b0;
      core_stall_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dbg_req) begin
            state_q      <= DRAIN;
            core_stall_q <= 1'b1;
          end
        end
        DRAIN: begin
          // An abandoned request takes priority over starting the access.
          if (!dbg_req) begin
            state_q      <= IDLE;
            core_stall_q <= 1'b0;
          end else if (!wb0_valid && !wb1_valid) begin
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // Read data sampled here is the pre-write value on a combined read/write.
          state_q     <= ACK;
          dbg_ack_q   <= 1'b1;
          dbg_rdata_q <= rf_rd1;
        end
        ACK: begin
          if (!dbg_req) begin
            state_q      <= IDLE;
            dbg_ack_q    <= 1'b0;
            core_stall_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          dbg_ack_q    <= 1'b0;
          core_stall_q <= 1'b0;
        end
      endcase
    end
  end

  // Writeback grant: only in IDLE/DRAIN, decided from the valids alone, and
  // suppressed while reset is asserted so nothing handshakes during reset.
  always_comb begin
    arb_en    = !reset && ((state_q == IDLE) || (state_q == DRAIN));
    wb0_first = RR_MODE ? last_wb1_q : 1'b0;
    grant0    = arb_en && wb0_valid && (!wb1_valid || wb0_first);
    grant1    = arb_en && wb1_valid && !grant0;
  end

  // Round-robin pointer follows completed transfers only (ready equals grant).
  always_comb begin
    last_wb1_d = last_wb1_q;
    if (grant0) begin
      last_wb1_d = 1'b0;
    end else if (grant1) begin
      last_wb1_d = 1'b1;
    end
  end

  // Last-grant pointer register; after reset wb0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_wb1_q <= 1'b1;
    end else begin
      last_wb1_q <= last_wb1_d;
    end
  end

  // Write-port mux: debug write in ACCESS, otherwise the granted writeback.
  // A writeback to x0 still handshakes but never asserts the write enable.
  always_comb begin
    dbg_wr       = !reset && (state_q == ACCESS) && dbg_we && (dbg_addr != 5'd0);
    rf_regWrite  = 1'b0;
    rf_writeReg  = '0;
    rf_writeData = '0;
    if (dbg_wr) begin
      rf_regWrite  = 1'b1;
      rf_writeReg  = dbg_addr;
      rf_writeData = dbg_wdata;
    end else if (grant0) begin
      rf_regWrite  = (wb0_rd != 5'd0);
      rf_writeReg  = wb0_rd;
      rf_writeData = wb0_data;
    end else if (grant1) begin
      rf_regWrite  = (wb1_rd != 5'd0);
      rf_writeReg  = wb1_rd;
      rf_writeData = wb1_data;
    end
  end

  // Output drive; the registered flags are masked during the reset cycle itself.
  always_comb begin
    wb0_ready  = grant0;
    wb1_ready  = grant1;
    rf_rs1     = (state_q == ACCESS) ? dbg_addr : core_rs1;
    dbg_ack    = dbg_ack_q && !reset;
    core_stall = core_stall_q && !reset;
    dbg_rdata  = dbg_rdata_q;
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a register-file model feeds rf_rd1, and a
// scoreboard queue holds every write the port is expected to perform.
module tb_regfile_access_ctrl;

  logic        clk;
  logic        reset;
  logic        wb0_valid, wb1_valid;
  logic        wb0_ready, wb1_ready;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        dbg_req, dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [4:0]  core_rs1, rf_rs1;
  logic [31:0] rf_rd1;
  logic [4:0]  rf_writeReg;
  logic [31:0] rf_writeData;
  logic        rf_regWrite;
  logic        core_stall;

  // Fixed-priority instance shares the inputs; only its grants are observed.
  logic        fp_wb0_ready, fp_wb1_ready, fp_dbg_ack, fp_rf_regWrite, fp_core_stall;
  logic [31:0] fp_dbg_rdata, fp_rf_writeData;
  logic [4:0]  fp_rf_rs1, fp_rf_writeReg;
  logic [31:0] fp_rf_rd1;

  logic [31:0] rf_mem [32];
  logic [36:0] sb_q [$];
  logic [36:0] exp_wr;
  int          n_cmp;
  int          n_mis;

  regfile_access_ctrl #(.RR_ENABLE(1)) dut (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .core_rs1(core_rs1), .rf_rs1(rf_rs1), .rf_rd1(rf_rd1),
    .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData), .rf_regWrite(rf_regWrite),
    .core_stall(core_stall)
  );

  regfile_access_ctrl #(.RR_ENABLE(0)) dut_fp (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_ready(fp_wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(fp_wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(fp_dbg_ack), .dbg_rdata(fp_dbg_rdata),
    .core_rs1(core_rs1), .rf_rs1(fp_rf_rs1), .rf_rd1(fp_rf_rd1),
    .rf_writeReg(fp_rf_writeReg), .rf_writeData(fp_rf_writeData), .rf_regWrite(fp_rf_regWrite),
    .core_stall(fp_core_stall)
  );

  assign rf_rd1    = (rf_rs1 == 5'd0) ? 32'd0 : rf_mem[rf_rs1];
  assign fp_rf_rd1 = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write-port strobe must match the oldest expected write.
  always @(posedge clk) begin
    if (rf_regWrite === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_mis++;
        $display("FAIL sb_unexpected_write got x%0d=%h want no write", rf_writeReg, rf_writeData);
      end else begin
        exp_wr = sb_q.pop_front();
        if ({rf_writeReg, rf_writeData} !== exp_wr) begin
          n_mis++;
          $display("FAIL sb_write got x%0d=%h want x%0d=%h", rf_writeReg, rf_writeData,
                   exp_wr[36:32], exp_wr[31:0]);
        end
      end
      rf_mem[rf_writeReg] <= rf_writeData;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; dbg_req = 1'b1; wb0_valid = 1'b1; wb1_valid = 1'b1;
    wb0_rd = 5'd3; wb1_rd = 5'd4;
    #2;
    n_cmp++;
    if ({wb0_ready, wb1_ready, rf_regWrite, dbg_ack, core_stall} !== 5'b0) begin
      n_mis++; $display("FAIL reset_outputs got %b want 00000", {wb0_ready, wb1_ready, rf_regWrite, dbg_ack, core_stall});
    end
    step(); step(); #1;
    n_cmp++;
    if (dbg_rdata !== 32'd0) begin n_mis++; $display("FAIL reset_rdata got %h want 0", dbg_rdata); end
    reset = 1'b0; dbg_req = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;
    step(); #1;
    n_cmp++;
    if ({dbg_ack, core_stall, wb0_ready, wb1_ready} !== 4'b0) begin
      n_mis++; $display("FAIL reset_idle got %b want 0000", {dbg_ack, core_stall, wb0_ready, wb1_ready});
    end
  endtask

  task automatic test_round_robin();
    logic exp0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'hA0A0A0A0;
    wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'hB1B1B1B1;
    for (int i = 0; i < 4; i++) begin
      exp0 = (i % 2 == 0);
      sb_q.push_back(exp0 ? {5'd1, 32'hA0A0A0A0} : {5'd2, 32'hB1B1B1B1});
      #2;
      n_cmp++;
      if ({wb0_ready, wb1_ready} !== {exp0, !exp0}) begin
        n_mis++; $display("FAIL rr_grant%0d got %b want %b", i, {wb0_ready, wb1_ready}, {exp0, !exp0});
      end
      n_cmp++;
      if ({fp_wb0_ready, fp_wb1_ready} !== 2'b01) begin
        n_mis++; $display("FAIL fixed_grant%0d got %b want 01", i, {fp_wb0_ready, fp_wb1_ready});
      end
      step();
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
  endtask

  task automatic test_single_wb();
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
    sb_q.push_back({5'd5, 32'hDEADBEEF});
    #2;
    n_cmp++;
    if ({wb0_ready, wb1_ready, rf_regWrite, rf_writeReg, rf_writeData} !== {3'b101, 5'd5, 32'hDEADBEEF}) begin
      n_mis++; $display("FAIL single_wb0 got rdy=%b we=%b x%0d=%h want rdy=10 we=1 x5=deadbeef",
                        {wb0_ready, wb1_ready}, rf_regWrite, rf_writeReg, rf_writeData);
    end
    step();
    wb0_valid = 1'b0;
  endtask

  // Full debug transaction with one extra ACK hold cycle and a writeback
  // attempted during ACK that must not be granted.
  task automatic dbg_txn(input string nm, input logic we, input logic [4:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
    logic wr;
    wr = we && (a != 5'd0);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; core_rs1 = 5'd3;
    #2;
    n_cmp++;
    if (core_stall !== 1'b0) begin n_mis++; $display("FAIL %s_idle_stall got %b want 0", nm, core_stall); end
    step(); #1;
    n_cmp++;
    if ({core_stall, dbg_ack, rf_rs1} !== {2'b10, 5'd3}) begin
      n_mis++; $display("FAIL %s_drain got stall=%b ack=%b rs1=%0d want 1 0 3", nm, core_stall, dbg_ack, rf_rs1);
    end
    if (wr) sb_q.push_back({a, wd});
    step(); #1;
    n_cmp++;
    if ({core_stall, dbg_ack, rf_regWrite, rf_rs1} !== {2'b10, wr, a}) begin
      n_mis++; $display("FAIL %s_access got stall=%b ack=%b we=%b rs1=%0d want 1 0 %b %0d",
                        nm, core_stall, dbg_ack, rf_regWrite, rf_rs1, wr, a);
    end
    step(); #1;
    n_cmp++;
    if ({core_stall, dbg_ack, dbg_rdata} !== {2'b11, exp_rd}) begin
      n_mis++; $display("FAIL %s_ack got stall=%b ack=%b rdata=%h want 1 1 %h", nm, core_stall, dbg_ack, dbg_rdata, exp_rd);
    end
    wb0_valid = 1'b1; wb0_rd = 5'd6; wb0_data = 32'h66666666;
    #1;
    n_cmp++;
    if (wb0_ready !== 1'b0) begin n_mis++; $display("FAIL %s_ack_ready got %b want 0", nm, wb0_ready); end
    step();
    dbg_req = 1'b0; wb0_valid = 1'b0;
    #1;
    n_cmp++;
    if (dbg_ack !== 1'b1) begin n_mis++; $display("FAIL %s_ack_hold got %b want 1", nm, dbg_ack); end
    step(); #1;
    n_cmp++;
    if ({dbg_ack, core_stall} !== 2'b00) begin
      n_mis++; $display("FAIL %s_release got ack=%b stall=%b want 0 0", nm, dbg_ack, core_stall);
    end
    dbg_we = 1'b0;
  endtask

  task automatic test_drain();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h55555555; core_rs1 = 5'd4;
    wb1_valid = 1'b1; wb1_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      wb1_data = 32'h90 + i;
      sb_q.push_back({5'd9, 32'h90 + i});
      #2;
      n_cmp++;
      if ({wb1_ready, core_stall} !== {1'b1, (i > 0)}) begin
        n_mis++; $display("FAIL drain_wb1_%0d got rdy=%b stall=%b want 1 %b", i, wb1_ready, core_stall, (i > 0));
      end
      step();
    end
    wb1_valid = 1'b0;
    #1;
    n_cmp++;
    if ({core_stall, dbg_ack, rf_regWrite, rf_rs1} !== {3'b100, 5'd4}) begin
      n_mis++; $display("FAIL drain_wait got stall=%b ack=%b we=%b rs1=%0d want 1 0 0 4", core_stall, dbg_ack, rf_regWrite, rf_rs1);
    end
    sb_q.push_back({5'd9, 32'h55555555});
    step(); #1;
    n_cmp++;
    if ({rf_regWrite, rf_rs1} !== {1'b1, 5'd9}) begin
      n_mis++; $display("FAIL drain_access got we=%b rs1=%0d want 1 9", rf_regWrite, rf_rs1);
    end
    step(); #1;
    n_cmp++;
    if ({dbg_ack, dbg_rdata} !== {1'b1, 32'h92}) begin
      n_mis++; $display("FAIL drain_rmw_rdata got ack=%b rdata=%h want 1 00000092", dbg_ack, dbg_rdata);
    end
    dbg_req = 1'b0; dbg_we = 1'b0;
    step(); #1;
    n_cmp++;
    if ({dbg_ack, core_stall} !== 2'b00) begin
      n_mis++; $display("FAIL drain_release got ack=%b stall=%b want 0 0", dbg_ack, core_stall);
    end
  endtask

  task automatic test_drop_in_drain();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h0BAD0BAD;
    step();
    dbg_req = 1'b0;
    #1;
    n_cmp++;
    if (core_stall !== 1'b1) begin n_mis++; $display("FAIL drop_drain_stall got %b want 1", core_stall); end
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      n_cmp++;
      if ({dbg_ack, core_stall} !== 2'b00) begin
        n_mis++; $display("FAIL drop_idle%0d got ack=%b stall=%b want 0 0", i, dbg_ack, core_stall);
      end
    end
    dbg_we = 1'b0;
  endtask

  task automatic test_x0_writeback();
    wb0_valid = 1'b1; wb0_rd = 5'd0; wb0_data = 32'h00001234;
    #2;
    n_cmp++;
    if ({wb0_ready, rf_regWrite} !== 2'b10) begin
      n_mis++; $display("FAIL wb0_x0 got rdy=%b we=%b want 1 0", wb0_ready, rf_regWrite);
    end
    step();
    wb0_valid = 1'b0;
  endtask

  task automatic test_reset_mid_debug();
    // Reset during ACCESS suppresses the debug write.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd20; dbg_wdata = 32'h20202020;
    step(); step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({rf_regWrite, core_stall} !== 2'b00) begin
      n_mis++; $display("FAIL rst_access got we=%b stall=%b want 0 0", rf_regWrite, core_stall);
    end
    step();
    reset = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd7;
    // New request restarts from IDLE and reaches ACK.
    step(); step(); step(); #1;
    n_cmp++;
    if ({dbg_ack, dbg_rdata} !== {1'b1, 32'h12345678}) begin
      n_mis++; $display("FAIL rst_restart got ack=%b rdata=%h want 1 12345678", dbg_ack, dbg_rdata);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({dbg_ack, core_stall} !== 2'b00) begin
      n_mis++; $display("FAIL rst_in_ack got ack=%b stall=%b want 0 0", dbg_ack, core_stall);
    end
    step();
    reset = 1'b0; dbg_req = 1'b0;
    #1;
    n_cmp++;
    if ({dbg_ack, core_stall, dbg_rdata} !== {2'b00, 32'd0}) begin
      n_mis++; $display("FAIL rst_after_ack got ack=%b stall=%b rdata=%h want 0 0 0", dbg_ack, core_stall, dbg_rdata);
    end
    step();
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
    rf_mem[7] = 32'h12345678;
    reset = 1'b1;
    wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    core_rs1 = '0;

    test_reset();
    test_round_robin();
    test_single_wb();
    dbg_txn("rd_x7", 1'b0, 5'd7, 32'd0, 32'h12345678);
    dbg_txn("wr_x12", 1'b1, 5'd12, 32'hCAFEF00D, 32'd0);
    dbg_txn("rd_x12", 1'b0, 5'd12, 32'd0, 32'hCAFEF00D);
    test_drain();
    test_drop_in_drain();
    dbg_txn("wr_x0", 1'b1, 5'd0, 32'hFFFFFFFF, 32'd0);
    test_x0_writeback();
    test_reset_mid_debug();
    dbg_txn("rd_x5", 1'b0, 5'd5, 32'd0, 32'hDEADBEEF);

    step();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_mis++; $display("FAIL sb_leftover got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
